// File: rtl/bram32_copy_pkg.sv
// Shared definitions for the bram32 copy/fill bus master.
//   AW_DEF / DW_DEF       : default address / data widths of the bram32 port
//   MODE_COPY / MODE_FILL : values of the mode command bit
//   state_t               : FSM state encoding (3-bit)
package bram32_copy_pkg;

   localparam int AW_DEF = 16;
   localparam int DW_DEF = 32;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CAP  = 3'd2,
      S_WR   = 3'd3,
      S_FIN  = 3'd4
   } state_t;

endpackage

// File: rtl/bram32_addr_gen.sv
// Address pointer for one side (source or destination) of a block transfer.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   load, base         : load the pointer with a new base address
//   inc                : advance the pointer by one word (wraps modulo 2^AW)
//   ptr                : current pointer
//   ptr_inc            : pointer value after the next increment
module bram32_addr_gen
   import bram32_copy_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          load,
   input  logic          inc,
   input  logic [AW-1:0] base,
   output logic [AW-1:0] ptr,
   output logic [AW-1:0] ptr_inc
);

   localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

   // Natural overflow of the AW-bit add gives the wrap to address 0.
   assign ptr_inc = ptr + ONE;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ptr <= '0;
      end else if (load) begin
         ptr <= base;
      end else if (inc) begin
         ptr <= ptr_inc;
      end
   end

endmodule

// File: rtl/bram32_copy.sv
// Bus master for one bram32 single-port memory: block copy (src->dst) or
// block fill (constant->dst) of len words, one command at a time.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   start              : command strobe, accepted only in IDLE
//   mode               : 0 = copy, 1 = fill
//   src, dst, len      : source base, destination base, word count (0 legal)
//   fill               : fill value
//   busy               : command in progress
//   done               : one-cycle completion pulse
//   a, we, dout        : bram32 address, write enable, write data (registered)
//   di                 : bram32 read data, valid one cycle after a read address
module bram32_copy
   import bram32_copy_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          start,
   input  logic          mode,
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] dst,
   input  logic [AW-1:0] len,
   input  logic [DW-1:0] fill,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] a,
   output logic          we,
   output logic [DW-1:0] dout,
   input  logic [DW-1:0] di
);

   localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

   state_t        state;
   logic          mode_q;
   logic [DW-1:0] fill_q;
   logic [AW-1:0] rem;
   logic [AW-1:0] src_ptr, src_ptr_inc;
   logic [AW-1:0] dst_ptr, dst_ptr_inc;
   logic          accept;
   logic          step;

   assign accept = (state == S_IDLE) && start;
   assign step   = (state == S_WR);

   bram32_addr_gen #(.AW(AW)) u_src_gen (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .load      (accept),
      .inc       (step),
      .base      (src),
      .ptr       (src_ptr),
      .ptr_inc   (src_ptr_inc)
   );

   bram32_addr_gen #(.AW(AW)) u_dst_gen (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .load      (accept),
      .inc       (step),
      .base      (dst),
      .ptr       (dst_ptr),
      .ptr_inc   (dst_ptr_inc)
   );

   // Fill value is pure data; it only needs to be valid once a command runs.
   always_ff @(posedge sys_clk) begin
      if (accept) begin
         fill_q <= fill;
      end
   end

   // Outputs are registered on the edge that enters a state, so a/we/dout
   // are already presented to the memory for the whole of RD and WR.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state  <= S_IDLE;
         mode_q <= MODE_COPY;
         rem    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         a      <= '0;
         we     <= 1'b0;
         dout   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy   <= 1'b1;
                  rem    <= len;
                  mode_q <= mode;
                  if (len == '0) begin
                     state <= S_FIN;
                  end else if (mode == MODE_FILL) begin
                     state <= S_WR;
                     a     <= dst;
                     we    <= 1'b1;
                     dout  <= fill;
                  end else begin
                     state <= S_RD;
                     a     <= src;
                  end
               end
            end
            S_RD: begin
               state <= S_CAP;
            end
            S_CAP: begin
               // The write-data register doubles as the copy buffer: the
               // word read in RD is captured straight into it.
               state <= S_WR;
               a     <= dst_ptr;
               we    <= 1'b1;
               dout  <= di;
            end
            S_WR: begin
               rem <= rem - ONE;
               if (rem == ONE) begin
                  state <= S_FIN;
                  we    <= 1'b0;
               end else if (mode_q == MODE_FILL) begin
                  a     <= dst_ptr_inc;
                  dout  <= fill_q;
               end else begin
                  state <= S_RD;
                  we    <= 1'b0;
                  a     <= src_ptr_inc;
               end
            end
            S_FIN: begin
               // done is registered here, so the pulse lands one cycle later,
               // coinciding with busy dropping.
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
